// File: rtl/game_pkg.sv
// Shared game constants: FSM state encoding, default pointer hit-box and lives,
// plus the overlap helper used by the pointer-drawing, menu and collision blocks.
package game_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ARMED     = 2'd1;
  localparam logic [1:0] ST_INVULN    = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  localparam int CURSOR_W_DEF = 16;
  localparam int CURSOR_H_DEF = 16;
  localparam int LIVES_DEF    = 3;

  // origin <= pos < origin+size, widened to 13 bits so boxes near 4095 never wrap
  function automatic logic in_span(input logic [11:0] pos,
                                   input logic [11:0] origin,
                                   input logic [12:0] size);
    logic [12:0] p13;
    logic [12:0] o13;
    p13 = {1'b0, pos};
    o13 = {1'b0, origin};
    return (p13 >= o13) && (p13 < (o13 + size));
  endfunction

endpackage

// File: rtl/vblnk_edge.sv
// Vertical-blank rising-edge detector: frame_edge is high in the cycle where
// vblnk_in is high and its one-cycle delayed copy is still low.
module vblnk_edge (
  input  logic pclk,
  input  logic rst,
  input  logic vblnk_in,
  output logic frame_edge
);

  logic vblnk_d;

  // one-cycle delayed copy of vertical blank
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk_in;
    end
  end

  assign frame_edge = vblnk_in & ~vblnk_d;

endmodule

// File: rtl/collision_detector.sv
// Pointer/obstacle collision detector: counts at most one hit per frame, manages
// lives and post-hit invulnerability, and flags game over.
module collision_detector
  import game_pkg::*;
#(
  parameter int CURSOR_W      = CURSOR_W_DEF,
  parameter int CURSOR_H      = CURSOR_H_DEF,
  parameter int LIVES         = LIVES_DEF,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        game_on,
  input  logic        vblnk_in,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic        hit_pulse,
  output logic [2:0]  lives_left,
  output logic        invuln,
  output logic        game_over
);

  logic        frame_edge;
  logic [1:0]  state_r, state_nxt;
  logic [11:0] mx_r, my_r;
  logic        frame_hit_r, frame_hit_nxt;
  logic [7:0]  cnt_r, cnt_nxt;
  logic [2:0]  lives_nxt;
  logic        hit_pulse_nxt, invuln_nxt, game_over_nxt;
  logic        pix_hit, hit_seen;

  vblnk_edge u_vblnk_edge (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .frame_edge (frame_edge)
  );

  // the edge-cycle pixel is still judged against the previous frame's pointer
  assign pix_hit  = (obstacle_x != 12'd0)
                  && in_span(obstacle_x, mx_r, 13'(CURSOR_W))
                  && in_span(obstacle_y, my_r, 13'(CURSOR_H));
  assign hit_seen = frame_hit_r | pix_hit;

  // next-state and next-output logic; game_on low overrides everything
  always_comb begin
    state_nxt     = state_r;
    lives_nxt     = lives_left;
    cnt_nxt       = cnt_r;
    frame_hit_nxt = frame_hit_r;
    hit_pulse_nxt = 1'b0;
    invuln_nxt    = invuln;
    game_over_nxt = game_over;
    if (!game_on) begin
      state_nxt     = ST_IDLE;
      lives_nxt     = 3'(LIVES);
      cnt_nxt       = 8'd0;
      frame_hit_nxt = 1'b0;
      invuln_nxt    = 1'b0;
      game_over_nxt = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt     = ST_ARMED;
          lives_nxt     = 3'(LIVES);
          cnt_nxt       = 8'd0;
          frame_hit_nxt = 1'b0;
          invuln_nxt    = 1'b0;
          game_over_nxt = 1'b0;
        end
        ST_ARMED: begin
          if (frame_edge) begin
            frame_hit_nxt = 1'b0;
            if (hit_seen) begin
              hit_pulse_nxt = 1'b1;
              lives_nxt     = lives_left - 3'd1;
              if (lives_left == 3'd1) begin
                state_nxt     = ST_GAME_OVER;
                game_over_nxt = 1'b1;
              end else begin
                state_nxt  = ST_INVULN;
                cnt_nxt    = 8'(INVULN_FRAMES);
                invuln_nxt = 1'b1;
              end
            end else begin
              state_nxt = ST_ARMED;
            end
          end else begin
            frame_hit_nxt = hit_seen;
          end
        end
        ST_INVULN: begin
          frame_hit_nxt = 1'b0;
          invuln_nxt    = 1'b1;
          if (frame_edge) begin
            cnt_nxt = cnt_r - 8'd1;
            if (cnt_r == 8'd1) begin
              state_nxt  = ST_ARMED;
              invuln_nxt = 1'b0;
            end else begin
              state_nxt = ST_INVULN;
            end
          end else begin
            cnt_nxt = cnt_r;
          end
        end
        ST_GAME_OVER: begin
          frame_hit_nxt = 1'b0;
          lives_nxt     = 3'd0;
          invuln_nxt    = 1'b0;
          game_over_nxt = 1'b1;
        end
        default: begin
          state_nxt     = ST_IDLE;
          lives_nxt     = 3'(LIVES);
          cnt_nxt       = 8'd0;
          frame_hit_nxt = 1'b0;
          invuln_nxt    = 1'b0;
          game_over_nxt = 1'b0;
        end
      endcase
    end
  end

  // state, pointer latch and registered outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      mx_r        <= 12'd0;
      my_r        <= 12'd0;
      frame_hit_r <= 1'b0;
      cnt_r       <= 8'd0;
      hit_pulse   <= 1'b0;
      lives_left  <= 3'(LIVES);
      invuln      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      if (frame_edge) begin
        mx_r <= mouse_xpos;
        my_r <= mouse_ypos;
      end else begin
        mx_r <= mx_r;
        my_r <= my_r;
      end
      state_r     <= state_nxt;
      frame_hit_r <= frame_hit_nxt;
      cnt_r       <= cnt_nxt;
      hit_pulse   <= hit_pulse_nxt;
      lives_left  <= lives_nxt;
      invuln      <= invuln_nxt;
      game_over   <= game_over_nxt;
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: vector table for overlap geometry plus
// hand-written sequences for invulnerability, game over, game_on drop and reset.
module tb_collision_detector;

  logic        pclk = 1'b0;
  logic        rst;
  logic        game_on;
  logic        vblnk_in;
  logic [11:0] obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
  logic        hit_pulse, invuln, game_over;
  logic [2:0]  lives_left;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] mxp;
    logic [11:0] myp;
    logic [11:0] ox;
    logic [11:0] oy;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[9];

  collision_detector #(.INVULN_FRAMES(2)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .game_on    (game_on),
    .vblnk_in   (vblnk_in),
    .obstacle_x (obstacle_x),
    .obstacle_y (obstacle_y),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .hit_pulse  (hit_pulse),
    .lives_left (lives_left),
    .invuln     (invuln),
    .game_over  (game_over)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; game_on = 1'b0; vblnk_in = 1'b0;
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic start_game();
    game_on = 1'b1;
    step();
  endtask

  // one cycle with vblnk rising; outputs afterwards reflect that edge
  task automatic edge_cycle(input logic [11:0] ox, input logic [11:0] oy);
    obstacle_x = ox; obstacle_y = oy; vblnk_in = 1'b1;
    step();
    obstacle_x = 12'd0; obstacle_y = 12'd0; vblnk_in = 1'b0;
  endtask

  task automatic latch_mouse(input logic [11:0] x, input logic [11:0] y);
    mouse_xpos = x; mouse_ypos = y;
    step();
    edge_cycle(12'd0, 12'd0);
  endtask

  // one pixel mid-frame, then an idle cycle, then the closing frame edge
  task automatic frame(input logic [11:0] ox, input logic [11:0] oy);
    obstacle_x = ox; obstacle_y = oy;
    step();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    step();
    edge_cycle(12'd0, 12'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] lives_exp;
    logic       hit_exp;

    vecs[0] = '{12'd100,  12'd100,  12'd110,  12'd105,  1'b1};
    vecs[1] = '{12'd100,  12'd100,  12'd116,  12'd100,  1'b0};
    vecs[2] = '{12'd100,  12'd100,  12'd100,  12'd116,  1'b0};
    vecs[3] = '{12'd100,  12'd100,  12'd115,  12'd115,  1'b1};
    vecs[4] = '{12'd4090, 12'd4090, 12'd4095, 12'd4095, 1'b1};
    vecs[5] = '{12'd4090, 12'd4090, 12'd5,    12'd5,    1'b0};
    vecs[6] = '{12'd100,  12'd100,  12'd99,   12'd100,  1'b0};
    vecs[7] = '{12'd100,  12'd100,  12'd100,  12'd100,  1'b1};
    vecs[8] = '{12'd0,    12'd0,    12'd0,    12'd5,    1'b0};

    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    rst = 1'b0; game_on = 1'b0; vblnk_in = 1'b0;
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    step();
    chk("reset_hit_pulse", hit_pulse, 1'b0);
    chk("reset_lives", lives_left, 3'd3);
    chk("reset_invuln", invuln, 1'b0);
    chk("reset_game_over", game_over, 1'b0);

    // geometry table; pointer moves after the latch to prove the latched copy is used
    for (int i = 0; i < 9; i++) begin
      do_reset();
      start_game();
      latch_mouse(vecs[i].mxp, vecs[i].myp);
      mouse_xpos = 12'd2000; mouse_ypos = 12'd2000;
      frame(vecs[i].ox, vecs[i].oy);
      chk($sformatf("vec%0d_hit", i), hit_pulse, vecs[i].exp_hit);
      chk($sformatf("vec%0d_lives", i), lives_left, vecs[i].exp_hit ? 3'd2 : 3'd3);
      chk($sformatf("vec%0d_invuln", i), invuln, vecs[i].exp_hit);
      step();
      chk($sformatf("vec%0d_pulse_width", i), hit_pulse, 1'b0);
    end

    // hit pixel arriving in the edge cycle counts for the ending frame
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    step();
    edge_cycle(12'd110, 12'd105);
    chk("edge_pixel_hit", hit_pulse, 1'b1);
    chk("edge_pixel_lives", lives_left, 3'd2);

    // many overlapping pixels in one frame give a single hit
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    for (int k = 0; k < 5; k++) begin
      obstacle_x = 12'd101 + 12'(k); obstacle_y = 12'd102;
      step();
    end
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    step();
    edge_cycle(12'd0, 12'd0);
    chk("multi_pix_hit", hit_pulse, 1'b1);
    chk("multi_pix_lives", lives_left, 3'd2);
    step();
    chk("multi_pix_single", hit_pulse, 1'b0);

    // overlap every frame with two-frame immunity: hits at frames 1, 4, 7
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    lives_exp = 3'd3;
    for (int f = 1; f <= 9; f++) begin
      frame(12'd110, 12'd105);
      hit_exp = (f == 1) || (f == 4) || (f == 7);
      if (hit_exp) lives_exp = lives_exp - 3'd1;
      chk($sformatf("seq_f%0d_hit", f), hit_pulse, hit_exp);
      chk($sformatf("seq_f%0d_lives", f), lives_left, lives_exp);
      chk($sformatf("seq_f%0d_invuln", f), invuln, (f == 1) || (f == 2) || (f == 4) || (f == 5));
      chk($sformatf("seq_f%0d_game_over", f), game_over, f >= 7);
    end
    game_on = 1'b0;
    step();
    chk("drop_after_over_game_over", game_over, 1'b0);
    chk("drop_after_over_lives", lives_left, 3'd3);

    // game_on falls in the very cycle of a hit frame edge
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    obstacle_x = 12'd110; obstacle_y = 12'd105;
    step();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    step();
    game_on = 1'b0;
    edge_cycle(12'd0, 12'd0);
    chk("drop_edge_hit", hit_pulse, 1'b0);
    chk("drop_edge_lives", lives_left, 3'd3);
    chk("drop_edge_invuln", invuln, 1'b0);
    game_on = 1'b1;
    step(); step();
    edge_cycle(12'd0, 12'd0);
    chk("drop_edge_no_stale_hit", hit_pulse, 1'b0);

    // asynchronous reset in the middle of immunity
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    frame(12'd110, 12'd105);
    chk("pre_rst_invuln", invuln, 1'b1);
    step();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_invuln", invuln, 1'b0);
    chk("async_rst_lives", lives_left, 3'd3);
    chk("async_rst_hit", hit_pulse, 1'b0);
    repeat (3) @(posedge pclk);
    #1 rst = 1'b1;
    step(); step();
    edge_cycle(12'd0, 12'd0);
    chk("post_rst_hit", hit_pulse, 1'b0);
    chk("post_rst_lives", lives_left, 3'd3);

    // pending frame hit is discarded by reset
    do_reset(); start_game(); latch_mouse(12'd100, 12'd100);
    obstacle_x = 12'd110; obstacle_y = 12'd105;
    step();
    obstacle_x = 12'd0; obstacle_y = 12'd0;
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
    step(); step();
    edge_cycle(12'd0, 12'd0);
    chk("pending_discard_hit", hit_pulse, 1'b0);
    chk("pending_discard_lives", lives_left, 3'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter CURSOR_W, default 16, meaning the pointer hit-box width in pixels.
REQ-002 SHALL have parameter CURSOR_H, default 16, meaning the pointer hit-box height in pixels.
REQ-003 SHALL have parameter LIVES, default 3, meaning the lives loaded at game start (range 1..7).
REQ-004 SHALL have parameter INVULN_FRAMES, default 60, meaning the frames of immunity after a hit (range 1..255).
REQ-005 pclk  in  1  pixel clock; single clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 game_on  in  1  game running; low forces IDLE.
REQ-008 vblnk_in  in  1  vertical blank from the timing chain.
REQ-009 obstacle_x  in  12  registered obstacle pixel hcount; 0 means no obstacle pixel this cycle.
REQ-010 obstacle_y  in  12  registered obstacle pixel vcount; 0 when obstacle_x is 0.
REQ-011 mouse_xpos  in  12  pointer top-left x.
REQ-012 mouse_ypos  in  12  pointer top-left y.
REQ-013 hit_pulse  out  1  one-cycle pulse per accepted hit.
REQ-014 lives_left  out  3  remaining lives.
REQ-015 invuln  out  1  high while hits are ignored.
REQ-016 game_over  out  1  high when lives are exhausted.

Function
REQ-017 States SHALL be IDLE, ARMED, INVULN, GAME_OVER; all outputs SHALL be registered.
REQ-018 Frame edge SHALL be the vblnk_in rising edge, detected from a one-cycle delayed copy.
REQ-019 At each frame edge, mouse_xpos/mouse_ypos SHALL be latched into mx/my; all comparisons in the following frame use the latched values.
REQ-020 Pixel valid SHALL be obstacle_x != 0.
REQ-021 Pixel inside SHALL be mx <= obstacle_x < mx+CURSOR_W and my <= obstacle_y < my+CURSOR_H, computed in 13 bits so there is no wrap at 4095.
REQ-022 In ARMED only, valid and inside SHALL set a sticky frame_hit flag; frame_hit SHALL clear on every frame edge and in every non-ARMED state.
REQ-023 A valid, inside pixel in the edge cycle itself SHALL count toward the frame just ending.
REQ-024 IDLE: lives_left=LIVES, invuln=0, game_over=0; the block SHALL go to ARMED on the cycle after game_on is sampled high.
REQ-025 ARMED, frame edge, frame_hit (or REQ-023 hit): hit_pulse=1 for exactly one cycle and lives_left decrements by 1.
REQ-026 If the decremented value is 0, the next state SHALL be GAME_OVER; otherwise the next state SHALL be INVULN with frame counter=INVULN_FRAMES.
REQ-027 INVULN: invuln=1; the counter SHALL decrement at each frame edge; at the edge where the counter equals 1, the next state SHALL be ARMED.
REQ-028 GAME_OVER: game_over=1 and lives_left=0; the block SHALL hold until game_on is low.
REQ-029 game_on low in any state SHALL force IDLE on the next cycle (lives reloaded, counters cleared, no hit_pulse), overriding a simultaneous frame-edge hit.
REQ-030 At most one hit SHALL be accepted per frame regardless of the number of overlapping pixels.

Reset
REQ-031 On rst low, asynchronously: state IDLE, hit_pulse=0, invuln=0, game_over=0, lives_left=LIVES, mx=my=0, frame_hit=0, counter=0, vblnk delay=0.
REQ-032 Reset asserted mid-INVULN or mid-frame SHALL discard all pending hit state; no hit_pulse SHALL appear after release until a new frame edge with a hit.

Structure
REQ-033 State encoding and default CURSOR_W/CURSOR_H/LIVES SHALL live in shared package game_pkg, reused by the pointer-drawing and menu blocks.
REQ-034 The vblnk rising-edge detector SHALL be sub-module vblnk_edge (pclk, rst, vblnk_in -> frame_edge pulse).

Verification
REQ-035 Latched mouse (100,100), pixel (110,105) valid in ARMED -> one hit_pulse at next vblnk edge, lives_left 3->2, invuln=1.
REQ-036 Pixels (116,100) and (100,116) with mouse (100,100) -> no hit (exclusive upper bound); pixel (115,115) -> hit.
REQ-037 INVULN_FRAMES=2, overlap every frame -> hits at frames 1, 4, 7; lives 2,1,0; game_over=1 after third hit.
REQ-038 Mouse (4090,4090), pixel (4095,4095) -> hit, no 12-bit wrap false negative; pixel (5,5) -> no hit.
REQ-039 game_on dropped in the same cycle as a hit frame edge -> no hit_pulse, IDLE, lives_left=3.
REQ-040 rst low mid-INVULN for 3 cycles -> IDLE, lives_left=3, invuln=0 immediately (asynchronous).
